// File: rtl/mat_inst_fetch.sv
// Instruction prefetcher for the matrix controller: fetches sequential words from a
// combinational-read instruction memory into a small FIFO, with start/stop/redirect control.
module mat_inst_fetch #(
   parameter int INST_MEM_ADDR_SIZE  = 32,
   parameter int INST_MEM_WIDTH_SIZE = 128,
   parameter int FIFO_DEPTH          = 4
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [INST_MEM_ADDR_SIZE-1:0]  start_pc,
   input  logic                           stop,
   input  logic                           redirect,
   input  logic [INST_MEM_ADDR_SIZE-1:0]  redirect_pc,
   output logic [INST_MEM_ADDR_SIZE-1:0]  inst_mem_addr,
   input  logic [INST_MEM_WIDTH_SIZE-1:0] inst_mem_value,
   output logic [INST_MEM_WIDTH_SIZE-1:0] inst,
   output logic [INST_MEM_ADDR_SIZE-1:0]  inst_pc,
   output logic                           inst_valid,
   input  logic                           inst_ready,
   output logic                           busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                         state_r, state_nxt_s;
   logic [INST_MEM_ADDR_SIZE-1:0]  fetch_pc_r, fetch_pc_nxt_s;
   logic [CNT_W-1:0]               count_r, count_nxt_s;
   logic [PTR_W-1:0]               head_r, head_nxt_s;
   logic [PTR_W-1:0]               tail_r, tail_nxt_s;
   logic [INST_MEM_WIDTH_SIZE-1:0] inst_q_r [FIFO_DEPTH];
   logic [INST_MEM_ADDR_SIZE-1:0]  pc_q_r   [FIFO_DEPTH];
   logic                           push_s;
   logic                           pop_s;

   // Full queue blocks the push even when the head is popped in the same cycle.
   assign push_s = (state_r == RUN) && (count_r != FULL_CNT) && !redirect;
   assign pop_s  = (count_r != {CNT_W{1'b0}}) && inst_ready && !redirect;

   // Next-state, pointer, count and fetch address computation.
   always_comb begin
      state_nxt_s    = state_r;
      fetch_pc_nxt_s = fetch_pc_r;
      count_nxt_s    = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      head_nxt_s     = head_r + PTR_W'(pop_s);
      tail_nxt_s     = tail_r + PTR_W'(push_s);
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s    = RUN;
               fetch_pc_nxt_s = start_pc;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN, DRAIN: begin
            if (redirect) begin
               state_nxt_s    = RUN;
               fetch_pc_nxt_s = redirect_pc;
               count_nxt_s    = {CNT_W{1'b0}};
               head_nxt_s     = {PTR_W{1'b0}};
               tail_nxt_s     = {PTR_W{1'b0}};
            end else if (state_r == RUN) begin
               if (push_s) begin
                  fetch_pc_nxt_s = fetch_pc_r + INST_MEM_ADDR_SIZE'(1);
               end else begin
                  fetch_pc_nxt_s = fetch_pc_r;
               end
               state_nxt_s = stop ? DRAIN : RUN;
            end else if (count_nxt_s == {CNT_W{1'b0}}) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         fetch_pc_r <= {INST_MEM_ADDR_SIZE{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         head_r     <= {PTR_W{1'b0}};
         tail_r     <= {PTR_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         fetch_pc_r <= fetch_pc_nxt_s;
         count_r    <= count_nxt_s;
         head_r     <= head_nxt_s;
         tail_r     <= tail_nxt_s;
      end
   end

   // Queue payload storage; contents are only meaningful below count_r.
   always_ff @(posedge clock) begin
      if (reset_n && push_s) begin
         inst_q_r[tail_r] <= inst_mem_value;
         pc_q_r[tail_r]   <= fetch_pc_r;
      end
   end

   assign inst_mem_addr = fetch_pc_r;
   assign inst          = inst_q_r[head_r];
   assign inst_pc       = pc_q_r[head_r];
   assign inst_valid    = (count_r != {CNT_W{1'b0}});
   assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_mat_inst_fetch.sv
// Directed self-checking bench for mat_inst_fetch; memory word k holds value k.
module tb_mat_inst_fetch;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         start, stop, redirect, inst_ready;
   logic [31:0]  start_pc, redirect_pc;
   logic [31:0]  inst_mem_addr, inst_pc;
   logic [127:0] inst_mem_value, inst;
   logic         inst_valid, busy;

   logic         w_start, w_stop, w_redirect, w_ready;
   logic [3:0]   w_start_pc, w_redirect_pc, w_addr, w_inst_pc;
   logic [127:0] w_value, w_inst;
   logic         w_valid, w_busy;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assign inst_mem_value = 128'(inst_mem_addr);
   assign w_value        = 128'(w_addr);

   mat_inst_fetch dut (
      .clock(clock), .reset_n(reset_n), .start(start), .start_pc(start_pc),
      .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_mem_addr(inst_mem_addr), .inst_mem_value(inst_mem_value),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .busy(busy)
   );

   mat_inst_fetch #(.INST_MEM_ADDR_SIZE(4)) dut_w (
      .clock(clock), .reset_n(reset_n), .start(w_start), .start_pc(w_start_pc),
      .stop(w_stop), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
      .inst_mem_addr(w_addr), .inst_mem_value(w_value),
      .inst(w_inst), .inst_pc(w_inst_pc), .inst_valid(w_valid),
      .inst_ready(w_ready), .busy(w_busy)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0; stop = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
      w_start = 1'b0; w_ready = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   // Start at pc 0 with backpressure and let n entries accumulate.
   task automatic fill(input int n);
      start = 1'b1; start_pc = 32'd0;
      step();
      start = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      start_pc = 32'd0; redirect_pc = 32'd0;
      w_stop = 1'b0; w_redirect = 1'b0; w_start_pc = 4'd0; w_redirect_pc = 4'd0;
      do_reset();
      check_eq("rst_valid", 128'(inst_valid), 128'(0));
      check_eq("rst_busy",  128'(busy),       128'(0));
      check_eq("rst_addr",  128'(inst_mem_addr), 128'(0));

      // Basic stream from pc 8
      inst_ready = 1'b1; start = 1'b1; start_pc = 32'd8;
      step();
      start = 1'b0;
      check_eq("s_valid_e1", 128'(inst_valid), 128'(0));
      check_eq("s_busy_e1",  128'(busy),       128'(1));
      check_eq("s_addr_e1",  128'(inst_mem_addr), 128'(8));
      for (int k = 0; k < 6; k++) begin
         step();
         check_eq("s_valid", 128'(inst_valid), 128'(1));
         check_eq("s_pc",    128'(inst_pc),    128'(8 + k));
         check_eq("s_inst",  inst,             128'(8 + k));
      end

      // Backpressure
      do_reset();
      fill(4);
      check_eq("bp_addr_full", 128'(inst_mem_addr), 128'(4));
      step();
      check_eq("bp_addr_hold", 128'(inst_mem_addr), 128'(4));
      check_eq("bp_inst_hold", inst,             128'(0));
      check_eq("bp_pc_hold",   128'(inst_pc),    128'(0));
      inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_eq("bp_valid", 128'(inst_valid), 128'(1));
         check_eq("bp_pc",    128'(inst_pc),    128'(i));
         check_eq("bp_inst",  inst,             128'(i));
         step();
      end

      // Redirect with 3 queued entries
      do_reset();
      fill(3);
      check_eq("rd_pre_pc",   128'(inst_pc),       128'(0));
      check_eq("rd_pre_addr", 128'(inst_mem_addr), 128'(3));
      redirect = 1'b1; redirect_pc = 32'd100; inst_ready = 1'b1;
      step();
      redirect = 1'b0;
      check_eq("rd_valid0", 128'(inst_valid),    128'(0));
      check_eq("rd_addr",   128'(inst_mem_addr), 128'(100));
      step();
      check_eq("rd_valid1", 128'(inst_valid), 128'(1));
      check_eq("rd_pc",     128'(inst_pc),    128'(100));
      check_eq("rd_inst",   inst,             128'(100));

      // Stop and drain with a full queue
      do_reset();
      fill(4);
      check_eq("dr_pc0", 128'(inst_pc), 128'(0));
      stop = 1'b1; inst_ready = 1'b1;
      step();
      stop = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check_eq("dr_busy",  128'(busy),          128'(1));
         check_eq("dr_valid", 128'(inst_valid),    128'(1));
         check_eq("dr_pc",    128'(inst_pc),       128'(i));
         check_eq("dr_addr",  128'(inst_mem_addr), 128'(4));
         step();
      end
      check_eq("dr_busy_end",  128'(busy),          128'(0));
      check_eq("dr_valid_end", 128'(inst_valid),    128'(0));
      check_eq("dr_addr_end",  128'(inst_mem_addr), 128'(4));

      // Address wrap on the 4-bit instance
      do_reset();
      w_start = 1'b1; w_start_pc = 4'd14; w_ready = 1'b1;
      step();
      w_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("wr_valid", 128'(w_valid), 128'(1));
         check_eq("wr_pc",    128'(w_inst_pc), 128'((14 + k) % 16));
         check_eq("wr_inst",  w_inst,           128'((14 + k) % 16));
      end

      // Reset mid-run, redirect ignored in IDLE, then restart
      do_reset();
      fill(2);
      check_eq("mr_valid_pre", 128'(inst_valid), 128'(1));
      reset_n = 1'b0; inst_ready = 1'b1;
      step();
      reset_n = 1'b1;
      check_eq("mr_valid", 128'(inst_valid),    128'(0));
      check_eq("mr_busy",  128'(busy),          128'(0));
      check_eq("mr_addr",  128'(inst_mem_addr), 128'(0));
      redirect = 1'b1; redirect_pc = 32'd50; stop = 1'b1;
      step();
      redirect = 1'b0; stop = 1'b0;
      check_eq("idle_rd_busy", 128'(busy),          128'(0));
      check_eq("idle_rd_addr", 128'(inst_mem_addr), 128'(0));
      start = 1'b1; start_pc = 32'd8;
      step();
      start = 1'b0;
      check_eq("mr_valid_e1", 128'(inst_valid), 128'(0));
      for (int k = 0; k < 2; k++) begin
         step();
         check_eq("mr_pc",   128'(inst_pc), 128'(8 + k));
         check_eq("mr_inst", inst,          128'(8 + k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mat_inst_fetch.md
MAT_INST_FETCH -- requirements
Module: mat_inst_fetch

Interface
REQ-001 SHALL take parameter INST_MEM_ADDR_SIZE, default 32, width of instruction-word addresses.
REQ-002 SHALL take parameter INST_MEM_WIDTH_SIZE, default 128, bits per instruction word.
REQ-003 SHALL take parameter FIFO_DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-004 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin fetching from start_pc (acts only in IDLE).
REQ-007 SHALL have port start_pc  input  INST_MEM_ADDR_SIZE  first word address.
REQ-008 SHALL have port stop  input  1  cease new fetches and drain the queue.
REQ-009 SHALL have port redirect  input  1  flush the queue and resume at redirect_pc.
REQ-010 SHALL have port redirect_pc  input  INST_MEM_ADDR_SIZE  new fetch address.
REQ-011 SHALL have port inst_mem_addr  output  INST_MEM_ADDR_SIZE  combinational-read address to instruction memory.
REQ-012 SHALL have port inst_mem_value  input  INST_MEM_WIDTH_SIZE  instruction memory data, valid in the same cycle as the address.
REQ-013 SHALL have port inst  output  INST_MEM_WIDTH_SIZE  head-of-queue instruction to the matrix controller.
REQ-014 SHALL have port inst_pc  output  INST_MEM_ADDR_SIZE  word address of inst.
REQ-015 SHALL have port inst_valid  output  1  queue non-empty.
REQ-016 SHALL have port inst_ready  input  1  consumer accepts inst this cycle.
REQ-017 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, RUN and DRAIN.
REQ-019 SHALL hold fetch_pc and count (0..FIFO_DEPTH) as registers; inst_mem_addr SHALL equal fetch_pc.
REQ-020 SHALL, on IDLE with start=1, set fetch_pc to start_pc and enter RUN; start SHALL be ignored in RUN and DRAIN.
REQ-021 SHALL push when in RUN, count < FIFO_DEPTH (value before the edge) and redirect=0: store {inst_mem_value, fetch_pc} at tail, fetch_pc += 1 modulo 2^INST_MEM_ADDR_SIZE.
REQ-022 SHALL NOT push when full, even if a pop occurs in the same cycle (no pop-bypass).
REQ-023 SHALL pop when inst_valid=1, inst_ready=1 and redirect=0; inst_ready with an empty queue SHALL have no effect.
REQ-024 SHALL update count as count + push - pop; a simultaneous push and pop SHALL leave count unchanged.
REQ-025 SHALL drive inst and inst_pc from the head entry and inst_valid = (count != 0); all three SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-026 SHALL, on stop=1 in RUN with redirect=0, enter DRAIN; no pushes occur in DRAIN.
REQ-027 SHALL go from DRAIN to IDLE at the edge where count becomes 0.
REQ-028 SHALL, on redirect=1 in RUN or DRAIN, set count to 0, reset head/tail, set fetch_pc to redirect_pc and enter RUN; redirect overrides stop, push and pop in that cycle.
REQ-029 SHALL ignore redirect and stop in IDLE.
REQ-030 SHALL give a latency of one edge from start/redirect sampled to the first push, so inst_valid rises after the second edge.
REQ-031 SHALL let head and tail pointers wrap modulo FIFO_DEPTH.

Reset
REQ-032 SHALL, with reset_n=0 at a rising edge, set the state to IDLE, count=0, fetch_pc=0, head=tail=0, and override all other inputs.
REQ-033 SHALL drive outputs after reset as follows: inst_valid=0, busy=0, inst_mem_addr=0; inst and inst_pc are don't-care while inst_valid=0.
REQ-034 SHALL, on reset mid-RUN or mid-DRAIN, discard queued entries; nothing SHALL be popped in the reset cycle.

Verification
REQ-035 Basic stream: memory word k = k, start with start_pc=8, inst_ready=1 held -> inst_valid rises after edge 2; inst_pc = 8, 9, 10, ... one per cycle, with inst equal to inst_pc.
REQ-036 Backpressure: start_pc=0, inst_ready=0 -> count saturates at 4 after 5 edges; inst_mem_addr holds at 4; inst holds at word 0; release -> words 0..7 delivered in order, none lost or duplicated.
REQ-037 Redirect: queue holding 3 entries (pc 0..2), redirect=1 with redirect_pc=100 and inst_ready=1 -> no pop; next cycle inst_valid=0; the following cycle inst_pc=100.
REQ-038 Stop/drain: RUN with 4 entries, stop=1, inst_ready=1 -> busy=1 while pc 0..3 are delivered; busy=0 and inst_valid=0 after the 4th pop; inst_mem_addr frozen at 4.
REQ-039 Wrap: INST_MEM_ADDR_SIZE=4, start_pc=14 -> inst_pc sequence 14, 15, 0, 1.
REQ-040 Reset mid-operation: reset_n=0 for one edge while 2 entries are queued -> inst_valid=0 and busy=0 next cycle; start in IDLE behaves as in REQ-035.
